// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arc4_pkg
// Purpose  : Shared types and constants for the ARC4 decryptor slice.
//            Holds the controller state encoding, the S-box size and the
//            ROM/RAM address map of the length-prefixed messages.
// Revision : 1.0  initial release
// ============================================================================
package arc4_pkg;

    localparam int SBOX_SIZE = 256;

    // Byte 0 of both the ciphertext ROM and the plaintext RAM holds the
    // message length; payload byte n lives at address DATA_ADDR_BASE+n-1.
    localparam logic [7:0] CT_LEN_ADDR    = 8'd0;
    localparam logic [7:0] DATA_ADDR_BASE = 8'd1;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_KSA_J  = 4'd1,
        ST_KSA_SW = 4'd2,
        ST_LEN_RD = 4'd3,
        ST_LEN_WR = 4'd4,
        ST_PG_J   = 4'd5,
        ST_PG_SW  = 4'd6,
        ST_PG_WR  = 4'd7,
        ST_DONE   = 4'd8
    } arc4_state_e;

endpackage
`default_nettype wire

// File: rtl/arc4_sbox.sv
`default_nettype none
// ============================================================================
// Module   : arc4_sbox
// Purpose  : 256 x 8 ARC4 state array built from registers.
//            Asynchronous reads of S[a] and of S[(S[a]+S[b]) mod 256];
//            one swap port exchanging S[a] and S[b] in a single cycle;
//            one init port writing S[a] = a.
// Ports    : clk        - rising-edge clock
//            init_we_i  - write S[idx_a_i] = idx_a_i (has priority)
//            swap_en_i  - swap S[idx_a_i] and S[idx_b_i]
//            idx_a_i    - index a (normally i)
//            idx_b_i    - index b (normally j)
//            s_a_o      - S[a]
//            s_t_o      - S[(S[a]+S[b]) mod 256], the keystream byte
// Revision : 1.0  initial release
// ============================================================================
module arc4_sbox (
    input  logic       clk,
    input  logic       init_we_i,
    input  logic       swap_en_i,
    input  logic [7:0] idx_a_i,
    input  logic [7:0] idx_b_i,
    output logic [7:0] s_a_o,
    output logic [7:0] s_t_o
);
    import arc4_pkg::*;

    // No reset: the controller rewrites every entry during INIT.
    logic [7:0] s_q [SBOX_SIZE];
    logic [7:0] w_s_b;
    logic [7:0] w_sum;

    assign s_a_o = s_q[idx_a_i];
    assign w_s_b = s_q[idx_b_i];
    assign w_sum = s_a_o + w_s_b;
    assign s_t_o = s_q[w_sum];

    // When a == b both writes target one entry with its own value, so the
    // array is left unchanged.
    always_ff @(posedge clk) begin
        if (init_we_i) begin
            s_q[idx_a_i] <= idx_a_i;
        end else if (swap_en_i) begin
            s_q[idx_a_i] <= w_s_b;
            s_q[idx_b_i] <= s_a_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arc4_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : arc4_decrypt
// Purpose  : ARC4 stream decryptor. Builds the S-box from the key (init +
//            KSA), runs the PRGA over a length-prefixed ciphertext held in
//            a synchronous ROM and writes the length-prefixed plaintext to
//            a RAM. One key per run; rdy rises when the message is done.
// Config   : ARC4_DROP_EN - when defined, 256 keystream bytes are generated
//            and discarded before the first payload byte (RC4-drop[256]).
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset (wins over en)
//            en         - run enable; low freezes all state
//            rdy        - decryption complete
//            key        - key, byte 0 in the most significant byte
//            ct_addr    - ciphertext ROM address (1-cycle read latency)
//            ct_rddata  - ciphertext ROM data
//            pt_addr    - plaintext RAM address
//            pt_rddata  - plaintext RAM read data (ignored)
//            pt_wrdata  - plaintext RAM write data
//            pt_wren    - plaintext RAM write strobe
// Revision : 1.0  initial release
// ============================================================================
module arc4_decrypt #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren
);
    import arc4_pkg::*;

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    arc4_state_e       state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0]        ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d;
    logic [7:0]        pt_wrdata_q, pt_wrdata_d;
    logic              rdy_q, rdy_d;
    logic [KIDX_W-1:0] kidx_q, kidx_d;   // i mod KEY_BYTES during the KSA
`ifdef ARC4_DROP_EN
    logic              drop_q, drop_d;   // discarding keystream, k counts steps
`endif

    logic [7:0] w_key_byte, w_idx_a, w_s_a, w_s_t, w_k_inc;
    logic [7:0] w_wr_addr, w_wr_data;
    logic       w_init_we, w_swap_en, w_write;
    logic       w_unused_rd;

    assign w_unused_rd = ^pt_rddata;
    assign w_k_inc     = k_q + 8'd1;

    arc4_sbox u_sbox (
        .clk       (clk),
        .init_we_i (w_init_we),
        .swap_en_i (w_swap_en),
        .idx_a_i   (w_idx_a),
        .idx_b_i   (j_q),
        .s_a_o     (w_s_a),
        .s_t_o     (w_s_t)
    );

    always_comb begin
        w_key_byte = key[8*KEY_BYTES-1 -: 8];
        for (int n = 1; n < KEY_BYTES; n++) begin
            if (kidx_q == KIDX_W'(n)) w_key_byte = key[8*(KEY_BYTES-n)-1 -: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        kidx_d      = kidx_q;
        ct_addr_d   = ct_addr_q;
        rdy_d       = rdy_q;
`ifdef ARC4_DROP_EN
        drop_d      = drop_q;
`endif
        w_init_we   = 1'b0;
        w_swap_en   = 1'b0;
        w_idx_a     = i_q;
        w_write     = 1'b0;
        w_wr_addr   = pt_addr_q;
        w_wr_data   = pt_wrdata_q;

        case (state_q)
            ST_INIT: begin
                w_init_we = en;
                i_d       = i_q + 8'd1;
                if (i_q == 8'hFF) state_d = ST_KSA_J;
            end
            ST_KSA_J: begin
                j_d     = j_q + w_s_a + w_key_byte;
                state_d = ST_KSA_SW;
            end
            ST_KSA_SW: begin
                w_swap_en = en;
                i_d       = i_q + 8'd1;
                kidx_d    = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
                if (i_q == 8'hFF) begin
                    state_d   = ST_LEN_RD;
                    ct_addr_d = CT_LEN_ADDR;  // ROM returns the length during LEN_WR
                end else begin
                    state_d = ST_KSA_J;
                end
            end
            ST_LEN_RD: begin
                i_d     = 8'd0;
                j_d     = 8'd0;
                k_d     = 8'd0;
                state_d = ST_LEN_WR;
            end
            ST_LEN_WR: begin
                w_write   = 1'b1;
                w_wr_addr = CT_LEN_ADDR;
                w_wr_data = ct_rddata;
                len_d     = ct_rddata;
                if (ct_rddata == 8'd0) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = ST_PG_J;
`ifdef ARC4_DROP_EN
                    drop_d  = 1'b1;
`else
                    ct_addr_d = DATA_ADDR_BASE;
`endif
                end
            end
            ST_PG_J: begin
                // j uses S at the advanced index, so look it up at i+1 now.
                w_idx_a = i_q + 8'd1;
                i_d     = i_q + 8'd1;
                j_d     = j_q + w_s_a;
                state_d = ST_PG_SW;
            end
            ST_PG_SW: begin
                w_swap_en = en;
                state_d   = ST_PG_WR;
`ifdef ARC4_DROP_EN
                if (drop_q) begin
                    k_d     = w_k_inc;
                    state_d = ST_PG_J;
                    if (k_q == 8'hFF) begin
                        drop_d    = 1'b0;
                        ct_addr_d = DATA_ADDR_BASE;
                    end
                end
`endif
            end
            ST_PG_WR: begin
                // S already swapped, so s_t is the keystream byte for this k.
                w_write   = 1'b1;
                w_wr_addr = DATA_ADDR_BASE + k_q;
                w_wr_data = ct_rddata ^ w_s_t;
                k_d       = w_k_inc;
                if (w_k_inc == len_q) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d   = ST_PG_J;
                    ct_addr_d = DATA_ADDR_BASE + w_k_inc;
                end
            end
            ST_DONE: begin
                rdy_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        pt_addr_d   = w_write ? w_wr_addr : pt_addr_q;
        pt_wrdata_d = w_write ? w_wr_data : pt_wrdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            kidx_q      <= '0;
            ct_addr_q   <= DATA_ADDR_BASE;
            pt_addr_q   <= DATA_ADDR_BASE;
            pt_wrdata_q <= 8'd0;
            rdy_q       <= 1'b0;
`ifdef ARC4_DROP_EN
            drop_q      <= 1'b0;
`endif
        end else if (en) begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            kidx_q      <= kidx_d;
            ct_addr_q   <= ct_addr_d;
            pt_addr_q   <= pt_addr_d;
            pt_wrdata_q <= pt_wrdata_d;
            rdy_q       <= rdy_d;
`ifdef ARC4_DROP_EN
            drop_q      <= drop_d;
`endif
        end
    end

    // Write-state outputs are driven combinationally so the RAM sees the
    // byte in the same cycle the ROM data is valid; elsewhere they hold.
    assign pt_wren   = w_write & en;
    assign pt_addr   = w_write ? w_wr_addr : pt_addr_q;
    assign pt_wrdata = w_write ? w_wr_data : pt_wrdata_q;
    assign ct_addr   = ct_addr_q;
    assign rdy       = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_arc4_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_arc4_decrypt
// Purpose  : Self-checking bench for arc4_decrypt: known-answer vectors,
//            zero length, pause, mid-run reset and random messages against
//            a plain software RC4 model. Honours ARC4_DROP_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_arc4_decrypt;

    localparam int KEY_BYTES = 3;
`ifdef ARC4_DROP_EN
    localparam int DROP_N = 256;
`else
    localparam int DROP_N = 0;
`endif
    localparam int LIMIT = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [23:0] key = 24'd0;
    logic [7:0]  ct_rddata = 8'd0;
    logic [7:0]  pt_rddata = 8'd0;
    logic        rdy, pt_wren;
    logic [7:0]  ct_addr, pt_addr, pt_wrdata;

    always #5 clk = ~clk;

    arc4_decrypt #(.KEY_BYTES(KEY_BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    // Synchronous ROM, one cycle of read latency.
    logic [7:0] rom [0:255];
    always @(posedge clk) ct_rddata <= rom[ct_addr];

    // RAM capture; ram_run tags which run wrote each byte.
    logic [7:0] ram [0:255];
    int         ram_run [0:255];
    int         run_id   = 0;
    int         wr_total = 0;
    always @(negedge clk) begin
        if (pt_wren === 1'b1) begin
            ram[pt_addr]     = pt_wrdata;
            ram_run[pt_addr] = run_id;
            wr_total++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain RC4 (optionally with discarded prefix) over the ROM contents.
    logic [7:0] exp_pt [0:255];
    function automatic void model(input logic [23:0] k);
        int s [256];
        int ii, jj, tmp, len;
        logic [7:0] kb;
        for (int a = 0; a < 256; a++) s[a] = a;
        jj = 0;
        for (int a = 0; a < 256; a++) begin
            kb  = 8'(k >> (8 * (KEY_BYTES - 1 - (a % KEY_BYTES))));
            jj  = (jj + s[a] + int'(kb)) % 256;
            tmp = s[a]; s[a] = s[jj]; s[jj] = tmp;
        end
        len = int'(rom[0]);
        exp_pt[0] = rom[0];
        ii = 0;
        jj = 0;
        for (int n = 1 - DROP_N; n <= len; n++) begin
            ii  = (ii + 1) % 256;
            jj  = (jj + s[ii]) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            if (n >= 1) exp_pt[n] = rom[n] ^ 8'(s[(s[ii] + s[jj]) % 256]);
        end
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, " rst pt_wren"},   {31'd0, pt_wren},   32'd0);
        chk({tag, " rst ct_addr"},   {24'd0, ct_addr},   32'd1);
        chk({tag, " rst pt_addr"},   {24'd0, pt_addr},   32'd1);
        chk({tag, " rst pt_wrdata"}, {24'd0, pt_wrdata}, 32'd0);
        chk({tag, " rst rdy"},       {31'd0, rdy},       32'd0);
    endtask

    task automatic run_case(input logic [23:0] k, input int len, input bit kat,
                            input logic [71:0] kat_pt, input int pause_at,
                            input int reset_at, input string tag);
        int         cyc, base, exp_lat;
        bit         frozen, reset_done;
        logic [7:0] s_ct, s_pa, s_pd, kb;
        logic       s_rdy;
        logic [71:0] kv;
        logic [31:0] act;
        key = k;
        model(k);
        en  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_id++;
        base       = wr_total;
        rst        = 1'b0;
        cyc        = 0;
        reset_done = 1'b0;
        while (rdy !== 1'b1 && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == pause_at) begin
                en = 1'b0;
                #1;
                s_ct = ct_addr; s_pa = pt_addr; s_pd = pt_wrdata; s_rdy = rdy;
                frozen = 1'b1;
                repeat (20) begin
                    @(posedge clk);
                    #1;
                    if (pt_wren !== 1'b0 || ct_addr !== s_ct || pt_addr !== s_pa ||
                        pt_wrdata !== s_pd || rdy !== s_rdy) frozen = 1'b0;
                end
                chk({tag, " pause frozen"}, {31'd0, frozen}, 32'd1);
                en = 1'b1;
            end
            if (cyc == reset_at && !reset_done) begin
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check_reset_values({tag, " midrun"});
                run_id++;
                base       = wr_total;
                rst        = 1'b0;
                cyc        = 0;
                reset_done = 1'b1;
            end
        end
        exp_lat = 770 + 3 * len + ((len > 0) ? 2 * DROP_N : 0);
        chk({tag, " latency"}, cyc, exp_lat);
        repeat (10) @(posedge clk);
        #1;
        chk({tag, " rdy held"},     {31'd0, rdy},       32'd1);
        chk({tag, " write count"},  wr_total - base,    len + 1);
        chk({tag, " ct_addr end"},  {24'd0, ct_addr},   len);
        chk({tag, " pt_addr end"},  {24'd0, pt_addr},   len);
        chk({tag, " pt_wrdata end"},{24'd0, pt_wrdata}, {24'd0, exp_pt[len]});
        for (int a = 0; a <= len; a++) begin
            act = (ram_run[a] == run_id) ? {24'd0, ram[a]} : 32'hDEAD;
            chk($sformatf("%s pt[%0d]", tag, a), act, {24'd0, exp_pt[a]});
        end
`ifndef ARC4_DROP_EN
        if (kat) begin
            kv = kat_pt;
            for (int n = 1; n <= len && n <= 9; n++) begin
                kb  = kv[8*(10-n)-1 -: 8];
                act = (ram_run[n] == run_id) ? {24'd0, ram[n]} : 32'hDEAD;
                chk($sformatf("%s kat[%0d]", tag, n), act, {24'd0, kb});
            end
        end
`endif
    endtask

    typedef struct {
        logic [23:0] key;
        int          len;
        logic [71:0] ct;
        bit          kat;
        logic [71:0] pt;
        int          pause_at;
        int          reset_at;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [71:0] cv;
        int          len;

        vecs[0] = '{24'h4B6579, 9, 72'hBBF316E8D940AF0AD3, 1'b1, 72'h506C61696E74657874,  -1,  -1};
        vecs[1] = '{24'h123456, 0, 72'h0,                  1'b1, 72'h0,                   -1,  -1};
        vecs[2] = '{24'h4B6579, 9, 72'hBBF316E8D940AF0AD3, 1'b1, 72'h506C61696E74657874, 784,  -1};
        vecs[3] = '{24'h4B6579, 9, 72'hBBF316E8D940AF0AD3, 1'b1, 72'h506C61696E74657874,  -1, 400};
        vecs[4] = '{24'h000000, 1, 72'h0,                  1'b0, 72'h0,                   -1,  -1};

        for (int a = 0; a < 256; a++) rom[a] = 8'(a);

        // Reset with en high.
        en  = 1'b1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_reset_values("initial");

        for (int v = 0; v < 5; v++) begin
            for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
            cv     = vecs[v].ct;
            rom[0] = 8'(vecs[v].len);
            for (int n = 1; n <= vecs[v].len && n <= 9; n++) rom[n] = cv[8*(10-n)-1 -: 8];
            run_case(vecs[v].key, vecs[v].len, vecs[v].kat, vecs[v].pt,
                     vecs[v].pause_at, vecs[v].reset_at, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 4; r++) begin
            len = (r == 3) ? 255 : int'($urandom_range(1, 40));
            for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
            rom[0] = 8'(len);
            run_case(24'($urandom), len, 1'b0, 72'h0, -1, -1, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
